// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU load/store path and the host/debug port.
// Optional grant/conflict counters are enabled with `define ARB_PERF_CNT_EN.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ack,
    output logic              o_cpu_stall,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_host_ack,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
`ifdef ARB_PERF_CNT_EN
    output logic [15:0]       o_cpu_grant_cnt,
    output logic [15:0]       o_host_grant_cnt,
    output logic [15:0]       o_conflict_cnt,
`endif
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_grant_cpu;
    logic                w_grant_host;
    logic                w_host_busy;
    logic                r_owner_host;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_host_rdata;
    logic                r_cpu_ack;
    logic                r_host_ack;
    logic [WAIT_W-1:0]   r_host_wait;

    // Next state and arbitration; grants exist only in IDLE
    always_comb begin
        w_next_state = r_state;
        w_grant_cpu  = 1'b0;
        w_grant_host = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cpu_req && i_host_req) begin
                    if (r_host_wait >= WAIT_W'(STARVE_MAX)) w_grant_host = 1'b1;
                    else                                    w_grant_cpu  = 1'b1;
                end else if (i_cpu_req) begin
                    w_grant_cpu = 1'b1;
                end else if (i_host_req) begin
                    w_grant_host = 1'b1;
                end
                if (i_cpu_req || i_host_req) w_next_state = S_ISSUE;
            end
            S_ISSUE: w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Host cycles spent on its own in-flight access are not counted as waiting
    assign w_host_busy = w_grant_host || ((r_state != S_IDLE) && r_owner_host);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner_host <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
            r_cpu_ack    <= 1'b0;
            r_host_ack   <= 1'b0;
            r_host_wait  <= '0;
        end else begin
            r_cpu_ack  <= 1'b0;
            r_host_ack <= 1'b0;
            if (w_grant_cpu || w_grant_host) begin
                r_owner_host <= w_grant_host;
                r_we         <= w_grant_host ? i_host_we    : i_cpu_we;
                r_addr       <= w_grant_host ? i_host_addr  : i_cpu_addr;
                r_wdata      <= w_grant_host ? i_host_wdata : i_cpu_wdata;
            end
            // Ack is raised so it is visible during RESP
            if (r_state == S_ISSUE) begin
                if (r_owner_host) r_host_ack <= 1'b1;
                else              r_cpu_ack  <= 1'b1;
            end
            if ((r_state == S_RESP) && !r_we) begin
                if (r_owner_host) r_host_rdata <= i_mem_rdata;
                else              r_cpu_rdata  <= i_mem_rdata;
            end
            if (!i_host_req || w_host_busy)
                r_host_wait <= '0;
            else if (r_host_wait < WAIT_W'(STARVE_MAX))
                r_host_wait <= r_host_wait + WAIT_W'(1);
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] r_cpu_grant_cnt;
    logic [15:0] r_host_grant_cnt;
    logic [15:0] r_conflict_cnt;

    // Saturating performance counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cpu_grant_cnt  <= '0;
            r_host_grant_cnt <= '0;
            r_conflict_cnt   <= '0;
        end else begin
            if (w_grant_cpu && (r_cpu_grant_cnt != 16'hFFFF))
                r_cpu_grant_cnt <= r_cpu_grant_cnt + 16'd1;
            if (w_grant_host && (r_host_grant_cnt != 16'hFFFF))
                r_host_grant_cnt <= r_host_grant_cnt + 16'd1;
            if ((r_state == S_IDLE) && i_cpu_req && i_host_req && (r_conflict_cnt != 16'hFFFF))
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign o_cpu_grant_cnt  = r_cpu_grant_cnt;
    assign o_host_grant_cnt = r_host_grant_cnt;
    assign o_conflict_cnt   = r_conflict_cnt;
`endif

    // Write strobe is gated by reset so an abandoned ISSUE cannot write
    assign o_mem_we     = (r_state == S_ISSUE) && r_we && !i_rst;
    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_wdata;
    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_host_rdata = r_host_rdata;
    assign o_cpu_ack    = r_cpu_ack;
    assign o_host_ack   = r_host_ack;
    assign o_cpu_stall  = i_cpu_req && !r_cpu_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural synchronous-read 64x32 RAM.
// Define ARB_PERF_CNT_EN for both files to exercise the counters.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [5:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [5:0]  host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic [31:0] host_rdata;
    logic        host_ack;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
`ifdef ARB_PERF_CNT_EN
    logic [15:0] cpu_grant_cnt, host_grant_cnt, conflict_cnt;
`endif

    bit [31:0] ram [64];
    bit [31:0] ram_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_rdata <= ram[mem_addr];
    end

    data_mem_arbiter #(.ADDR_W(6), .DATA_W(32), .STARVE_MAX(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack), .o_cpu_stall(cpu_stall),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_rdata(host_rdata), .o_host_ack(host_ack),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
`ifdef ARB_PERF_CNT_EN
        .o_cpu_grant_cnt(cpu_grant_cnt), .o_host_grant_cnt(host_grant_cnt), .o_conflict_cnt(conflict_cnt),
`endif
        .i_mem_rdata(ram_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one access to completion; returns ack latency and per-cycle observations
    task automatic do_access(input bit host, input bit we, input logic [5:0] addr,
                             input logic [31:0] wdata, output int lat, output int stall_n,
                             output int we_n, output int other_n, output logic [31:0] rd);
        lat = -1; stall_n = 0; we_n = 0; other_n = 0;
        if (host) begin
            host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        #1;
        for (int i = 0; i < 10; i++) begin
            if (cpu_stall) stall_n++;
            if (mem_we) we_n++;
            if (host ? cpu_ack : host_ack) other_n++;
            if (host ? host_ack : cpu_ack) begin
                lat = i;
                break;
            end
            tick();
        end
        cpu_req = 1'b0; host_req = 1'b0;
        tick();
        rd = host ? host_rdata : cpu_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++; if (cpu_ack !== 1'b0)      begin bad++; $display("FAIL reset_cpu_ack got=%b want=0", cpu_ack); end
        total++; if (host_ack !== 1'b0)     begin bad++; $display("FAIL reset_host_ack got=%b want=0", host_ack); end
        total++; if (cpu_rdata !== 32'h0)   begin bad++; $display("FAIL reset_cpu_rdata got=%h want=0", cpu_rdata); end
        total++; if (host_rdata !== 32'h0)  begin bad++; $display("FAIL reset_host_rdata got=%h want=0", host_rdata); end
        total++; if (mem_addr !== 6'h0)     begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0)   begin bad++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
        total++; if (mem_we !== 1'b0)       begin bad++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_host_write_cpu_load();
        int lat, st, wn, on;
        logic [31:0] rd;
        do_access(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, lat, st, wn, on, rd);
        total++; if (lat != 2) begin bad++; $display("FAIL hw_latency got=%0d want=2", lat); end
        total++; if (wn != 1)  begin bad++; $display("FAIL hw_mem_we_cycles got=%0d want=1", wn); end
        total++; if (on != 0)  begin bad++; $display("FAIL hw_cpu_ack got=%0d want=0", on); end
        do_access(1'b0, 1'b0, 6'd5, 32'h0, lat, st, wn, on, rd);
        total++; if (lat != 2) begin bad++; $display("FAIL cl_latency got=%0d want=2", lat); end
        total++; if (wn != 0)  begin bad++; $display("FAIL cl_mem_we_cycles got=%0d want=0", wn); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL cl_rdata got=%h want=deadbeef", rd); end
    endtask

    task automatic test_cpu_store_load();
        int lat, st, wn, on;
        logic [31:0] rd;
        do_access(1'b0, 1'b1, 6'd63, 32'h1, lat, st, wn, on, rd);
        total++; if (st != 2) begin bad++; $display("FAIL cs_stall_cycles got=%0d want=2", st); end
        total++; if (wn != 1) begin bad++; $display("FAIL cs_mem_we_cycles got=%0d want=1", wn); end
        total++; if (on != 0) begin bad++; $display("FAIL cs_host_ack got=%0d want=0", on); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL cs_rdata_kept got=%h want=deadbeef", rd); end
        do_access(1'b0, 1'b0, 6'd63, 32'h0, lat, st, wn, on, rd);
        total++; if (st != 2) begin bad++; $display("FAIL cld_stall_cycles got=%0d want=2", st); end
        total++; if (on != 0) begin bad++; $display("FAIL cld_host_ack got=%0d want=0", on); end
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL cld_rdata got=%h want=1", rd); end
    endtask

    task automatic test_drop_req();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5;
        #1;
        tick();
        cpu_req = 1'b0;
        tick();
        total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL drop_ack got=%b want=1", cpu_ack); end
        tick();
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL drop_ack_pulse got=%b want=0", cpu_ack); end
        total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL drop_rdata got=%h want=deadbeef", cpu_rdata); end
        tick();
    endtask

    task automatic test_starvation();
        string exp_seq = "CCCHCCCH";
        byte   seq [8];
        int    cyc [8];
        int    n = 0;
        cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 6'd1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'd2;
        #1;
        for (int k = 1; k <= 23; k++) begin
            tick();
            total++;
            if (cpu_ack && host_ack) begin bad++; $display("FAIL starve_both_ack cycle=%0d", k); end
            if ((cpu_ack || host_ack) && n < 8) begin
                seq[n] = cpu_ack ? "C" : "H";
                cyc[n] = k;
                n++;
            end
        end
        cpu_req = 1'b0; host_req = 1'b0;
        tick(); tick(); tick(); tick();
        total++; if (n != 8) begin bad++; $display("FAIL starve_ack_count got=%0d want=8", n); end
        for (int i = 0; i < n; i++) begin
            total++;
            if (seq[i] != exp_seq[i] || cyc[i] != 3 * i + 2) begin
                bad++;
                $display("FAIL starve_order idx=%0d got=%c@%0d want=%c@%0d", i, seq[i], cyc[i], exp_seq[i], 3 * i + 2);
            end
        end
    endtask

    task automatic test_simultaneous();
        int cpu_c = -1, host_c = -1;
        cpu_req = 1'b1;  cpu_we = 1'b0;  cpu_addr = 6'd5;
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'd63;
        #1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (cpu_ack && cpu_c < 0)   begin cpu_c = k;  cpu_req = 1'b0; end
            if (host_ack && host_c < 0) begin host_c = k; host_req = 1'b0; end
        end
        cpu_req = 1'b0; host_req = 1'b0;
        total++; if (cpu_c != 2)  begin bad++; $display("FAIL sim_cpu_ack_cycle got=%0d want=2", cpu_c); end
        total++; if (host_c != 5) begin bad++; $display("FAIL sim_host_ack_cycle got=%0d want=5", host_c); end
        total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sim_cpu_rdata got=%h want=deadbeef", cpu_rdata); end
        total++; if (host_rdata !== 32'h1) begin bad++; $display("FAIL sim_host_rdata got=%h want=1", host_rdata); end
    endtask

    task automatic test_reset_mid_access();
        int lat, st, wn, on;
        logic [31:0] rd;
        do_access(1'b0, 1'b1, 6'd7, 32'h12345678, lat, st, wn, on, rd);
        host_req = 1'b1; host_we = 1'b1; host_addr = 6'd7; host_wdata = 32'h0BAD0BAD;
        #1;
        tick();
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rma_issue_we got=%b want=1", mem_we); end
        rst = 1'b1; host_req = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rma_gated_we got=%b want=0", mem_we); end
        tick();
        total++; if (host_ack !== 1'b0)    begin bad++; $display("FAIL rma_host_ack got=%b want=0", host_ack); end
        total++; if (mem_addr !== 6'h0)    begin bad++; $display("FAIL rma_mem_addr got=%h want=0", mem_addr); end
        total++; if (mem_wdata !== 32'h0)  begin bad++; $display("FAIL rma_mem_wdata got=%h want=0", mem_wdata); end
        total++; if (cpu_rdata !== 32'h0)  begin bad++; $display("FAIL rma_cpu_rdata got=%h want=0", cpu_rdata); end
        total++; if (host_rdata !== 32'h0) begin bad++; $display("FAIL rma_host_rdata got=%h want=0", host_rdata); end
        rst = 1'b0;
        tick();
        total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL rma_late_ack got=%b want=0", host_ack); end
        tick();
        do_access(1'b0, 1'b0, 6'd7, 32'h0, lat, st, wn, on, rd);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL rma_ram_kept got=%h want=12345678", rd); end
    endtask

`ifdef ARB_PERF_CNT_EN
    task automatic test_perf_counters();
        int lat, st, wn, on;
        logic [31:0] rd;
        test_reset();
        total++; if (conflict_cnt !== 16'd0) begin bad++; $display("FAIL perf_reset got=%0d want=0", conflict_cnt); end
        test_simultaneous();
        do_access(1'b0, 1'b0, 6'd1, 32'h0, lat, st, wn, on, rd);
        do_access(1'b0, 1'b1, 6'd9, 32'h9, lat, st, wn, on, rd);
        do_access(1'b1, 1'b0, 6'd9, 32'h0, lat, st, wn, on, rd);
        total++; if (cpu_grant_cnt !== 16'd3)  begin bad++; $display("FAIL perf_cpu got=%0d want=3", cpu_grant_cnt); end
        total++; if (host_grant_cnt !== 16'd2) begin bad++; $display("FAIL perf_host got=%0d want=2", host_grant_cnt); end
        total++; if (conflict_cnt !== 16'd1)   begin bad++; $display("FAIL perf_conflict got=%0d want=1", conflict_cnt); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_host_write_cpu_load();
        test_cpu_store_load();
        test_drop_req();
        test_starvation();
        test_simultaneous();
        test_reset_mid_access();
`ifdef ARB_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
